// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the CPU fetch/data ports, the arbiter and the unified RAM.
// slave: arbiter view; master: CPU + memory view.
interface mem_port_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    localparam int unsigned STRB_W = DATA_W / 8;

    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic              i_err;
    logic [DATA_W-1:0] i_rdata;

    logic              d_req;
    logic              d_we;
    logic [STRB_W-1:0] d_wstrb;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic              d_err;
    logic [DATA_W-1:0] d_rdata;

    logic              mem_en;
    logic [STRB_W-1:0] mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        output i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_wstrb, d_addr, d_wdata, mem_rdata,
        input  i_ack, i_err, i_rdata, d_ack, d_err, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and load/store accesses onto one synchronous-read RAM.
// Define MEM_ARB_RR_EN for round-robin on contention; default is data-port priority.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    mem_port_arbiter_if.slave bus
);
    localparam int unsigned STRB_W = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic              win_d_q, win_d_d;   // 1 = data port owns the transaction
    logic              store_q, store_d;
    logic              i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic              d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_W-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic [STRB_W-1:0] mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              pick_d;
    logic [ADDR_W-1:0] pick_addr;
    logic              any_req;

    assign any_req   = bus.i_req | bus.d_req;
    assign pick_addr = pick_d ? bus.d_addr : bus.i_addr;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;  // 1 = data port received the most recent grant

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_d_q <= 1'b1;
        else if (state_q == IDLE && any_req)
            last_d_q <= pick_d;
    end

    assign pick_d = (bus.i_req & bus.d_req) ? ~last_d_q : bus.d_req;
`else
    assign pick_d = bus.d_req;
`endif

    // Next state and next values of every registered output
    always_comb begin
        state_d     = state_q;
        win_d_d     = win_d_q;
        store_d     = store_q;
        i_ack_d     = 1'b0;
        i_err_d     = 1'b0;
        d_ack_d     = 1'b0;
        d_err_d     = 1'b0;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = '0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    win_d_d = pick_d;
                    store_d = pick_d & bus.d_we;
                    if (pick_addr[1:0] != 2'b00) begin
                        // misaligned: answer immediately, memory untouched
                        state_d = RESP;
                        i_ack_d = ~pick_d;
                        i_err_d = ~pick_d;
                        d_ack_d = pick_d;
                        d_err_d = pick_d;
                    end else begin
                        state_d    = ISSUE;
                        mem_en_d   = 1'b1;
                        mem_addr_d = pick_addr;
                        if (pick_d && bus.d_we) begin
                            mem_we_d    = bus.d_wstrb;
                            mem_wdata_d = bus.d_wdata;
                        end
                    end
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: begin
                state_d = RESP;
                i_ack_d = ~win_d_q;
                d_ack_d = win_d_q;
                if (!store_q) begin
                    if (win_d_q)
                        d_rdata_d = bus.mem_rdata;
                    else
                        i_rdata_d = bus.mem_rdata;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            win_d_q     <= 1'b0;
            store_q     <= 1'b0;
            i_ack_q     <= 1'b0;
            i_err_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            d_err_q     <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            win_d_q     <= win_d_d;
            store_q     <= store_d;
            i_ack_q     <= i_ack_d;
            i_err_q     <= i_err_d;
            d_ack_q     <= d_ack_d;
            d_err_q     <= d_err_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.i_ack     = i_ack_q;
    assign bus.i_err     = i_err_q;
    assign bus.i_rdata   = i_rdata_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.d_err     = d_err_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
endmodule
